// File: rtl/i2c_cfg_seq.sv
// rtl/i2c_cfg_seq.sv - table-driven single-byte I2C write sequencer in front of i2c_dri
// Optional per-write readback verify is enabled by defining I2C_CFG_VERIFY_EN.
module i2c_cfg_seq #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int ADDR_BYTE = 2,
  parameter int REG_NUM   = 256,
  parameter int IDX_W     = 8,
  parameter int PWR_MS    = 20,
  parameter int PLS_W     = 4,
  parameter int BUSY_TO   = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  output logic [IDX_W-1:0]         rom_addr,
  input  logic [ADDR_BYTE*8+7:0]   rom_data,
  output logic                     i2c_pluse,
  output logic                     i2c_w_r,
  output logic [ADDR_BYTE*8-1:0]   i2c_addr,
  output logic [7:0]               i2c_data_in,
  output logic [3:0]               i2c_byte_len,
  input  logic                     i2c_busy,
  input  logic [7:0]               i2c_data_out,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [IDX_W-1:0]         cfg_idx
);

  localparam int AW     = ADDR_BYTE * 8;
  localparam int MS_CYC = CLK_FRE / 1000;

  typedef enum logic [3:0] {
    S_PWR, S_FETCH, S_LOAD, S_DLY, S_TRIG, S_WBH, S_WBL, S_NEXT,
    S_DONE, S_ERR, S_VRD, S_VBH, S_VBL, S_CMP
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      cyc_cnt, ms_cnt, wait_cnt;
  logic             ms_tick, pls_end, busy_to;

  assign ms_tick      = (cyc_cnt == 32'(MS_CYC - 1));
  assign pls_end      = (wait_cnt == 32'(PLS_W - 1));
  assign busy_to      = (wait_cnt == 32'(BUSY_TO - 1));
  assign rom_addr     = idx;
  assign cfg_idx      = idx;
  assign i2c_byte_len = 4'd1;

`ifndef I2C_CFG_VERIFY_EN
  logic unused_rd_data;
  assign unused_rd_data = ^i2c_data_out;
`endif

  always_comb begin
    state_nxt = state;
    i2c_pluse = (state == S_TRIG);
    i2c_w_r   = 1'b1;
    cfg_done  = (state == S_DONE);
    cfg_err   = (state == S_ERR);
    cfg_busy  = !((state == S_DONE) || (state == S_ERR));
`ifdef I2C_CFG_VERIFY_EN
    if (state == S_VRD) i2c_pluse = 1'b1;
    if ((state == S_VRD) || (state == S_VBH) || (state == S_VBL) || (state == S_CMP)) i2c_w_r = 1'b0;
`endif
    case (state)
      S_PWR:   if (ms_cnt == 32'(PWR_MS)) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      // An all-ones register address marks an inline delay entry.
      S_LOAD:  state_nxt = (rom_data[AW+7:8] == {AW{1'b1}}) ? S_DLY : S_TRIG;
      S_DLY:   if (ms_cnt == {24'd0, i2c_data_in}) state_nxt = S_NEXT;
      S_TRIG:  if (pls_end) state_nxt = S_WBH;
      S_WBH:   if (i2c_busy) state_nxt = S_WBL;
               else if (busy_to) state_nxt = S_ERR;
`ifdef I2C_CFG_VERIFY_EN
      S_WBL:   if (!i2c_busy) state_nxt = S_VRD;
               else if (busy_to) state_nxt = S_ERR;
      S_VRD:   if (pls_end) state_nxt = S_VBH;
      S_VBH:   if (i2c_busy) state_nxt = S_VBL;
               else if (busy_to) state_nxt = S_ERR;
      S_VBL:   if (!i2c_busy) state_nxt = S_CMP;
               else if (busy_to) state_nxt = S_ERR;
      S_CMP:   state_nxt = (i2c_data_out == i2c_data_in) ? S_NEXT : S_ERR;
`else
      S_WBL:   if (!i2c_busy) state_nxt = S_NEXT;
               else if (busy_to) state_nxt = S_ERR;
`endif
      S_NEXT:  state_nxt = (idx == IDX_W'(REG_NUM - 1)) ? S_DONE : S_FETCH;
      S_DONE,
      S_ERR:   if (cfg_start) state_nxt = S_FETCH;
      default: state_nxt = S_PWR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_PWR;
      idx         <= '0;
      cyc_cnt     <= '0;
      ms_cnt      <= '0;
      wait_cnt    <= '0;
      i2c_addr    <= '0;
      i2c_data_in <= '0;
    end else begin
      state <= state_nxt;
      // Every counter restarts on state entry so PWR/DLY/TRIG/timeouts all share them.
      if (state_nxt != state) begin
        cyc_cnt  <= '0;
        ms_cnt   <= '0;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 32'd1;
        if (ms_tick) begin
          cyc_cnt <= '0;
          ms_cnt  <= ms_cnt + 32'd1;
        end else begin
          cyc_cnt <= cyc_cnt + 32'd1;
        end
      end
      if (state == S_LOAD) begin
        i2c_addr    <= rom_data[AW+7:8];
        i2c_data_in <= rom_data[7:0];
      end
      if ((state == S_NEXT) && (state_nxt == S_FETCH)) idx <= idx + 1'b1;
      if (((state == S_DONE) || (state == S_ERR)) && cfg_start) idx <= '0;
    end
  end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// tb/tb_i2c_cfg_seq.sv - directed self-checking bench for i2c_cfg_seq
`timescale 1ns/1ps
module tb_i2c_cfg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic        i2c_pluse, i2c_w_r;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_in, i2c_data_out;
  logic [3:0]  i2c_byte_len;
  logic        i2c_busy = 1'b0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [7:0]  cfg_idx;

  i2c_cfg_seq #(
    .CLK_FRE(10_000), .ADDR_BYTE(2), .REG_NUM(3), .IDX_W(8),
    .PWR_MS(2), .PLS_W(4), .BUSY_TO(50)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_pluse(i2c_pluse), .i2c_w_r(i2c_w_r), .i2c_addr(i2c_addr),
    .i2c_data_in(i2c_data_in), .i2c_byte_len(i2c_byte_len),
    .i2c_busy(i2c_busy), .i2c_data_out(i2c_data_out),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_idx(cfg_idx)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [0:2];
  always @(posedge clk) rom_data <= (rom_addr < 8'd3) ? rom[rom_addr[1:0]] : 24'h0;

  logic [7:0] rb_3103 = 8'h11;
  assign i2c_data_out = (i2c_addr == 16'h3103) ? rb_3103 : i2c_data_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor plus busy model: busy rises 5 cycles after a pluse rise and holds 20 cycles.
  int          rise_cyc[$], fall_cyc[$], width_q[$], bfall_cyc[$];
  logic [15:0] addr_q[$];
  logic [7:0]  data_q[$];
  logic        wr_q[$];
  int          block_idx = -1;
  int          err_cyc = -1;
  int          bcnt = 0, width = 0;
  logic        pl_q = 1'b0, bsy_q = 1'b0, err_q = 1'b0;

  always @(negedge clk) begin
    if (bcnt != 0) bcnt = (bcnt == 25) ? 0 : bcnt + 1;
    if (i2c_pluse && !pl_q) begin
      rise_cyc.push_back(cyc);
      addr_q.push_back(i2c_addr);
      data_q.push_back(i2c_data_in);
      wr_q.push_back(i2c_w_r);
      if (rise_cyc.size() - 1 != block_idx) bcnt = 1;
      width = 0;
    end
    if (i2c_pluse) width++;
    if (!i2c_pluse && pl_q) begin
      fall_cyc.push_back(cyc);
      width_q.push_back(width);
    end
    i2c_busy = (bcnt >= 5) && (bcnt < 25);
    if (!i2c_busy && bsy_q) bfall_cyc.push_back(cyc);
    if (cfg_err && !err_q) err_cyc = cyc;
    pl_q  = i2c_pluse;
    bsy_q = i2c_busy;
    err_q = cfg_err;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rise_cyc.delete(); fall_cyc.delete(); width_q.delete(); bfall_cyc.delete();
    addr_q.delete(); data_q.delete(); wr_q.delete();
    err_cyc = -1;
  endtask

  task automatic start_pulse();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cfg_done || cfg_err) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_pluse(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i2c_pluse) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [15:0] exp_a [0:2] = '{16'h3008, 16'h3103, 16'h3017};
  logic [7:0]  exp_d [0:2] = '{8'h02, 8'h11, 8'hFF};

  initial begin
    bit ok;
    int c0;
    rom[0] = 24'h300802;
    rom[1] = 24'h310311;
    rom[2] = 24'h3017FF;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pluse", i2c_pluse, 0);
    chk("rst_w_r", i2c_w_r, 1);
    chk("rst_byte_len", i2c_byte_len, 1);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_idx", cfg_idx, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_addr", i2c_addr, 0);
    chk("rst_data", i2c_data_in, 0);
    chk("rst_pwr_busy", cfg_busy, 1);
    c0 = cyc;
    rst = 1'b0;

`ifdef I2C_CFG_VERIFY_EN
    wait_end(3000, ok);
    chk("t6_end_seen", ok, 1);
    chk("t6_done", cfg_done, 1);
    chk("t6_err", cfg_err, 0);
    chk("t6_idx", cfg_idx, 2);
    chk("t6_pluse_cnt", rise_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_wr%0d", i), wr_q[i], (i % 2 == 0) ? 1 : 0);
      chk($sformatf("t6_addr%0d", i), addr_q[i], exp_a[i/2]);
    end

    rb_3103 = 8'h10;
    clear_logs();
    start_pulse();
    wait_end(3000, ok);
    chk("t6b_end_seen", ok, 1);
    chk("t6b_err", cfg_err, 1);
    chk("t6b_done", cfg_done, 0);
    chk("t6b_idx", cfg_idx, 1);
    chk("t6b_pluse_cnt", rise_cyc.size(), 4);
`else
    // T1 with T4 part one: a start pulse during entry 0 must be dropped.
    wait_pluse(200, ok);
    chk("t4_first_pluse_seen", ok, 1);
    start_pulse();
    wait_end(2000, ok);
    chk("t1_end_seen", ok, 1);
    chk("t1_done", cfg_done, 1);
    chk("t1_err", cfg_err, 0);
    chk("t1_idx", cfg_idx, 2);
    chk("t1_busy", cfg_busy, 0);
    chk("t1_pluse_cnt", rise_cyc.size(), 3);
    chk("t1_pwr_wait", (rise_cyc[0] - c0) >= 20, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_width%0d", i), width_q[i], 4);
      chk($sformatf("t1_addr%0d", i), addr_q[i], exp_a[i]);
      chk($sformatf("t1_data%0d", i), data_q[i], exp_d[i]);
      chk($sformatf("t1_wr%0d", i), wr_q[i], 1);
    end

    // T4 part two: start from DONE clears done and reruns the table.
    clear_logs();
    start_pulse();
    chk("t4_done_cleared", cfg_done, 0);
    chk("t4_busy_again", cfg_busy, 1);
    wait_end(2000, ok);
    chk("t4_end_seen", ok, 1);
    chk("t4_done", cfg_done, 1);
    chk("t4_pluse_cnt", rise_cyc.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_addr%0d", i), addr_q[i], exp_a[i]);

    // T2: delay entry of 3 ms in slot 1.
    rom[1] = 24'hFFFF03;
    clear_logs();
    start_pulse();
    wait_end(2000, ok);
    chk("t2_end_seen", ok, 1);
    chk("t2_done", cfg_done, 1);
    chk("t2_idx", cfg_idx, 2);
    chk("t2_pluse_cnt", rise_cyc.size(), 2);
    chk("t2_addr0", addr_q[0], 16'h3008);
    chk("t2_addr1", addr_q[1], 16'h3017);
    chk("t2_data1", data_q[1], 8'hFF);
    chk("t2_gap", (rise_cyc[1] - bfall_cyc[0]) >= 30, 1);

    // T3: busy never rises for entry 1.
    rom[1] = 24'h310311;
    block_idx = 1;
    clear_logs();
    start_pulse();
    wait_end(2000, ok);
    chk("t3_end_seen", ok, 1);
    chk("t3_err", cfg_err, 1);
    chk("t3_done", cfg_done, 0);
    chk("t3_idx", cfg_idx, 1);
    chk("t3_busy", cfg_busy, 0);
    chk("t3_err_latency", err_cyc - fall_cyc[1], 50);
    repeat (100) @(negedge clk);
    chk("t3_no_more_pluse", rise_cyc.size(), 2);
    chk("t3_err_held", cfg_err, 1);
    block_idx = -1;

    // T5: reset while pluse is high.
    clear_logs();
    start_pulse();
    chk("t5_err_cleared", cfg_err, 0);
    wait_pluse(200, ok);
    chk("t5_pluse_seen", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_pluse_drop", i2c_pluse, 0);
    chk("t5_idx_rst", cfg_idx, 0);
    chk("t5_busy_pwr", cfg_busy, 1);
    c0 = cyc;
    rst = 1'b0;
    clear_logs();
    wait_end(2000, ok);
    chk("t5_end_seen", ok, 1);
    chk("t5_done", cfg_done, 1);
    chk("t5_pluse_cnt", rise_cyc.size(), 3);
    chk("t5_pwr_wait", (rise_cyc[0] - c0) >= 20, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
